// File: rtl/tetris_field_mem.sv
// Playfield SRAM controller: pixel-rate display reads, blank-time cell writes
// through a small queue, collision queries and a full-field clear engine.
module tetris_field_mem #(
    parameter int FIELD_X0   = 220,
    parameter int FIELD_Y0   = 20,
    parameter int CELL_PX    = 20,
    parameter int COLS       = 10,
    parameter int ROWS       = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        VGA_CTRL_CLK,
    input  logic        RST,
    input  logic [9:0]  px,
    input  logic [9:0]  py,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_col,
    input  logic [4:0]  wr_row,
    input  logic [11:0] wr_color,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic [3:0]  rd_col,
    input  logic [4:0]  rd_row,
    output logic        rd_data_valid,
    output logic [11:0] rd_color,
    input  logic        clr_start,
    output logic        clr_busy,
    output logic [3:0]  pix_r,
    output logic [3:0]  pix_g,
    output logic [3:0]  pix_b,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam logic [9:0] X_LO  = 10'(FIELD_X0);
    localparam logic [9:0] X_HI  = 10'(FIELD_X0 + COLS * CELL_PX);
    localparam logic [9:0] Y_ORG = 10'(FIELD_Y0);
    localparam logic [9:0] Y_LO  = 10'(FIELD_Y0 + 2 * CELL_PX);
    localparam logic [9:0] Y_HI  = 10'(FIELD_Y0 + ROWS * CELL_PX);
    localparam logic [9:0] CELL  = 10'(CELL_PX);
    localparam logic [3:0] COL_LAST = 4'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    typedef struct packed {
        logic [3:0]  col;
        logic [4:0]  row;
        logic [11:0] color;
    } cell_wr_t;

    function automatic logic [17:0] cell_addr(input logic [3:0] col, input logic [4:0] row);
        return {1'b0, col, row, 8'h00};
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    state_t        state, state_nx;
    logic          run_en;
    logic [3:0]    clr_col;
    logic [4:0]    clr_row;
    logic          clr_last;
    logic          in_win, bus_free;
    logic [3:0]    disp_col;
    logic [4:0]    disp_row;

    cell_wr_t      fifo_mem [FIFO_DEPTH];
    cell_wr_t      fifo_head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty, fifo_full;
    logic          push, pop;

    logic          clr_wr, fifo_wr, rd_fire;
    logic          wr_in_range, rd_in_range;
    logic          dq_oe;
    logic [15:0]   dq_out;
    logic          dq_low_unused;

    assign in_win   = (px >= X_LO) && (px < X_HI) && (py >= Y_LO) && (py < Y_HI);
    assign bus_free = !in_win;
    assign disp_col = 4'((px - X_LO) / CELL);
    assign disp_row = 5'((py - Y_ORG) / CELL);

    assign wr_in_range = (wr_col <= COL_LAST) && (wr_row <= ROW_LAST);
    assign rd_in_range = (rd_col <= COL_LAST) && (rd_row <= ROW_LAST);

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_FULL);
    assign fifo_head  = fifo_mem[rd_ptr];

    assign clr_busy = (state == S_CLEAR);
    assign wr_ready = !fifo_full && (state == S_IDLE);
    assign rd_ready = bus_free && (state == S_IDLE) && fifo_empty;

    // run_en holds the bus quiet for the first cycle out of reset so the write
    // strobe never depends combinationally on RST.
    assign clr_last = (clr_col == COL_LAST) && (clr_row == ROW_LAST);
    assign clr_wr   = run_en && (state == S_CLEAR) && bus_free;
    assign fifo_wr  = run_en && (state == S_IDLE) && bus_free && !fifo_empty && !clr_start;
    assign rd_fire  = rd_valid && rd_ready;

    // Out-of-range writes are consumed by the handshake but never enter the queue.
    assign push = wr_valid && wr_ready && wr_in_range && !clr_start;
    assign pop  = fifo_wr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
        if (!RST) begin
            state  <= S_CLEAR;
            run_en <= 1'b0;
        end else begin
            state  <= state_nx;
            run_en <= 1'b1;
        end
    end

    // NOTE: next-state gets its default first so no path through the block can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_CLEAR: if (!clr_start && clr_wr && clr_last) state_nx = S_IDLE;
            S_IDLE:  if (clr_start) state_nx = S_CLEAR;
        endcase
    end

    always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
        if (!RST) begin
            clr_col <= '0;
            clr_row <= '0;
        end else if (clr_start) begin
            clr_col <= '0;
            clr_row <= '0;
        end else if (clr_wr) begin
            if (clr_row == ROW_LAST) begin
                clr_row <= '0;
                clr_col <= clr_last ? 4'd0 : clr_col + 4'd1;
            end else begin
                clr_row <= clr_row + 5'd1;
            end
        end
    end

    always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (clr_start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: queue storage is deliberately left without reset; the pointers and
    // count define which entries are meaningful.
    always_ff @(posedge VGA_CTRL_CLK) begin
        if (push) fifo_mem[wr_ptr] <= '{col: wr_col, row: wr_row, color: wr_color};
    end

    // One bus owner per cycle: display, then clear, queued write, query.
    always_comb begin
        SRAM_ADDR = cell_addr(disp_col, disp_row);
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b0;
        dq_oe     = 1'b0;
        dq_out    = '0;
        if (clr_wr) begin
            SRAM_ADDR = cell_addr(clr_col, clr_row);
            SRAM_WE_N = 1'b0;
            SRAM_OE_N = 1'b1;
            dq_oe     = 1'b1;
        end else if (fifo_wr) begin
            SRAM_ADDR = cell_addr(fifo_head.col, fifo_head.row);
            SRAM_WE_N = 1'b0;
            SRAM_OE_N = 1'b1;
            dq_oe     = 1'b1;
            dq_out    = {fifo_head.color, 4'h0};
        end else if (rd_fire && rd_in_range) begin
            SRAM_ADDR = cell_addr(rd_col, rd_row);
        end
    end

    assign SRAM_DQ       = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_CE_N     = 1'b0;
    assign SRAM_UB_N     = 1'b0;
    assign SRAM_LB_N     = 1'b0;
    assign dq_low_unused = ^SRAM_DQ[3:0];

    always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
        if (!RST) begin
            rd_data_valid <= 1'b0;
            rd_color      <= '0;
            pix_r         <= '0;
            pix_g         <= '0;
            pix_b         <= '0;
        end else begin
            rd_data_valid <= rd_fire;
            if (rd_fire) rd_color <= rd_in_range ? SRAM_DQ[15:4] : 12'hFFF;
            {pix_r, pix_g, pix_b} <= in_win ? SRAM_DQ[15:4] : 12'h000;
        end
    end

endmodule

// File: tb/tb_tetris_field_mem.sv
// Directed bench for tetris_field_mem with a behavioural asynchronous SRAM model.
module tb_tetris_field_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  px, py;
    logic        wr_valid, wr_ready;
    logic [3:0]  wr_col;
    logic [4:0]  wr_row;
    logic [11:0] wr_color;
    logic        rd_valid, rd_ready;
    logic [3:0]  rd_col;
    logic [4:0]  rd_row;
    logic        rd_data_valid;
    logic [11:0] rd_color;
    logic        clr_start, clr_busy;
    logic [3:0]  pix_r, pix_g, pix_b;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tetris_field_mem dut (
        .VGA_CTRL_CLK (clk),
        .RST          (rst_n),
        .px           (px),
        .py           (py),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_col       (wr_col),
        .wr_row       (wr_row),
        .wr_color     (wr_color),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_col       (rd_col),
        .rd_row       (rd_row),
        .rd_data_valid(rd_data_valid),
        .rd_color     (rd_color),
        .clr_start    (clr_start),
        .clr_busy     (clr_busy),
        .pix_r        (pix_r),
        .pix_g        (pix_g),
        .pix_b        (pix_b),
        .SRAM_ADDR    (SRAM_ADDR),
        .SRAM_DQ      (SRAM_DQ),
        .SRAM_WE_N    (SRAM_WE_N),
        .SRAM_OE_N    (SRAM_OE_N),
        .SRAM_CE_N    (SRAM_CE_N),
        .SRAM_UB_N    (SRAM_UB_N),
        .SRAM_LB_N    (SRAM_LB_N)
    );

    // SRAM model: cells preloaded with garbage so that clears and wall answers are visible.
    logic [15:0] sram [0:511];
    logic [8:0]  sram_idx;
    bit          sram_init_done = 1'b0;
    int          we_count = 0;
    int          nz_writes = 0;
    logic [17:0] wlog_addr [$];
    logic [15:0] wlog_data [$];

    assign sram_idx = SRAM_ADDR[16:8];
    assign SRAM_DQ  = (!SRAM_OE_N && SRAM_WE_N && !SRAM_CE_N) ? sram[sram_idx] : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_init_done) begin
            for (int i = 0; i < 512; i++) sram[i] = 16'hABC0;
            sram_init_done = 1'b1;
        end else if (!SRAM_WE_N) begin
            sram[sram_idx] = SRAM_DQ;
            we_count = we_count + 1;
            if (SRAM_DQ !== 16'h0000) nz_writes = nz_writes + 1;
            wlog_addr.push_back(SRAM_ADDR);
            wlog_data.push_back(SRAM_DQ);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] cell_addr(input logic [3:0] c, input logic [4:0] r);
        return {1'b0, c, r, 8'h00};
    endfunction

    function automatic logic [15:0] peek(input logic [3:0] c, input logic [4:0] r);
        return sram[{c, r}];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic [3:0] c, input logic [4:0] r, input logic [11:0] color,
                              output bit ok);
        wr_col = c; wr_row = r; wr_color = color; wr_valid = 1'b1;
        #1;
        ok = wr_ready;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic query(input string tag, input logic [3:0] c, input logic [4:0] r,
                         input logic [11:0] exp);
        int waited = 0;
        rd_col = c; rd_row = r; rd_valid = 1'b1;
        #1;
        while (!rd_ready && waited < 50) begin
            step();
            waited++;
        end
        check({tag, "_ready"}, rd_ready, 1'b1);
        step();
        rd_valid = 1'b0;
        check({tag, "_valid"}, rd_data_valid, 1'b1);
        check({tag, "_color"}, rd_color, exp);
        step();
        check({tag, "_valid_drop"}, rd_data_valid, 1'b0);
    endtask

    task automatic wait_clear(input string tag);
        int base = we_count;
        int cycles = 0;
        while ((we_count - base) < 220 && cycles < 3000) begin
            step();
            cycles++;
        end
        check({tag, "_busy_drop"}, clr_busy, 1'b0);
        check({tag, "_wr_ready"}, wr_ready, 1'b1);
        repeat (3) step();
        check({tag, "_writes"}, we_count - base, 220);
    endtask

    initial begin
        bit ok;
        int base, lb, nz;
        logic [3:0]  qc [3];
        logic [4:0]  qr [3];
        logic [11:0] qd [3];
        qc = '{4'd1, 4'd2, 4'd3};
        qr = '{5'd3, 5'd4, 5'd6};
        qd = '{12'h111, 12'h222, 12'h333};

        rst_n = 1'b0; px = '0; py = '0; clr_start = 1'b0;
        wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_color = '0;
        rd_valid = 1'b0; rd_col = '0; rd_row = '0;
        repeat (3) step();

        // Reset state
        check("rst_busy", clr_busy, 1'b1);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_rd_ready", rd_ready, 1'b0);
        check("rst_rd_valid", rd_data_valid, 1'b0);
        check("rst_rd_color", rd_color, 12'h000);
        check("rst_pix", {pix_r, pix_g, pix_b}, 12'h000);
        check("rst_we_n", SRAM_WE_N, 1'b1);
        check("rst_oe_n", SRAM_OE_N, 1'b0);
        check("rst_no_writes", we_count, 0);

        // Automatic clear after reset, in col-major order
        lb = wlog_addr.size();
        rst_n = 1'b1;
        wait_clear("init");
        check("init_first", wlog_addr[lb], cell_addr(4'd0, 5'd0));
        check("init_row21", wlog_addr[lb + 21], cell_addr(4'd0, 5'd21));
        check("init_col1", wlog_addr[lb + 22], cell_addr(4'd1, 5'd0));
        check("init_last", wlog_addr[lb + 219], cell_addr(4'd9, 5'd21));
        nz = 0;
        for (int c = 0; c < 10; c++)
            for (int r = 0; r < 22; r++)
                if (peek(4'(c), 5'(r)) !== 16'h0000) nz++;
        check("init_field_zero", nz, 0);
        query("q35", 4'd3, 5'd5, 12'h000);

        // Write held off during the visible window, then displayed
        px = 10'd300; py = 10'd70;
        step();
        push_write(4'd4, 5'd2, 12'h0FF, ok);
        check("w42_accept", ok, 1'b1);
        base = we_count;
        repeat (8) step();
        check("w42_stalled", we_count - base, 0);
        check("win_rd_ready", rd_ready, 1'b0);
        px = 10'd0; py = 10'd0;
        #1;
        check("w42_we_n", SRAM_WE_N, 1'b0);
        check("w42_addr", SRAM_ADDR, cell_addr(4'd4, 5'd2));
        check("w42_dq", SRAM_DQ, 16'h0FF0);
        step();
        check("w42_one_write", we_count - base, 1);
        check("w42_we_release", SRAM_WE_N, 1'b1);
        px = 10'd300; py = 10'd70;
        step();
        check("pix_cell42", {pix_r, pix_g, pix_b}, 12'h0FF);
        px = 10'd219;
        step();
        check("pix_left_edge", {pix_r, pix_g, pix_b}, 12'h000);
        px = 10'd300; py = 10'd50;
        step();
        check("pix_hidden_row", {pix_r, pix_g, pix_b}, 12'h000);

        // Minimum write latency while the bus is free
        px = 10'd0; py = 10'd0;
        push_write(4'd1, 5'd1, 12'h123, ok);
        check("w11_accept", ok, 1'b1);
        check("w11_we_n", SRAM_WE_N, 1'b0);
        check("w11_addr", SRAM_ADDR, cell_addr(4'd1, 5'd1));
        step();
        check("w11_mem", peek(4'd1, 5'd1), 16'h1230);

        // Queue fills at four entries, then drains in order
        px = 10'd300; py = 10'd70;
        for (int i = 0; i < 4; i++) begin
            push_write(qc[i % 3], qr[i % 3], qd[i % 3] + 12'(i / 3), ok);
            check("fifo_accept", ok, 1'b1);
        end
        push_write(4'd6, 5'd8, 12'h555, ok);
        check("fifo_full_reject", ok, 1'b0);
        lb = wlog_addr.size();
        px = 10'd0; py = 10'd0;
        repeat (4) step();
        check("fifo_drain_count", wlog_addr.size() - lb, 4);
        for (int i = 0; i < 4; i++) begin
            check("fifo_order_addr", wlog_addr[lb + i], cell_addr(qc[i % 3], qr[i % 3]));
            check("fifo_order_data", wlog_data[lb + i], {qd[i % 3] + 12'(i / 3), 4'h0});
        end
        step();
        check("fifo_no_extra", wlog_addr.size() - lb, 4);

        // Out-of-range query and write
        base = we_count;
        query("q_col10", 4'd10, 5'd3, 12'hFFF);
        query("q_row22", 4'd3, 5'd22, 12'hFFF);
        push_write(4'd0, 5'd22, 12'h0AA, ok);
        check("w022_accept", ok, 1'b1);
        repeat (4) step();
        check("w022_no_write", we_count - base, 0);
        check("w022_mem", peek(4'd0, 5'd22), 16'hABC0);

        // Clear with writes pending; a write in the clr_start cycle is lost
        px = 10'd300; py = 10'd70;
        push_write(4'd7, 5'd3, 12'h700, ok);
        push_write(4'd8, 5'd4, 12'h800, ok);
        push_write(4'd9, 5'd21, 12'h900, ok);
        wr_col = 4'd2; wr_row = 5'd2; wr_color = 12'h222; wr_valid = 1'b1; clr_start = 1'b1;
        step();
        wr_valid = 1'b0; clr_start = 1'b0;
        check("mid_busy", clr_busy, 1'b1);
        check("mid_wr_ready", wr_ready, 1'b0);
        nz = nz_writes;
        px = 10'd0; py = 10'd0;
        wait_clear("mid");
        check("mid_flushed", nz_writes - nz, 0);
        query("q73", 4'd7, 5'd3, 12'h000);
        query("q94", 4'd9, 5'd21, 12'h000);
        query("q22", 4'd2, 5'd2, 12'h000);
        query("q42", 4'd4, 5'd2, 12'h000);
        query("q13", 4'd1, 5'd3, 12'h000);

        // Restart at clear count 100
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        lb = wlog_addr.size();
        for (int i = 0; i < 400 && (wlog_addr.size() - lb) < 100; i++) step();
        px = 10'd300; py = 10'd70; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        check("rs_count100", wlog_addr.size() - lb, 100);
        lb = wlog_addr.size();
        px = 10'd0; py = 10'd0;
        wait_clear("restart");
        check("rs_first", wlog_addr[lb], cell_addr(4'd0, 5'd0));
        check("rs_mid", wlog_addr[lb + 100], cell_addr(4'd4, 5'd12));
        check("rs_last", wlog_addr[lb + 219], cell_addr(4'd9, 5'd21));

        // Reset asserted mid-clear drops the strobe at once
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (10) step();
        check("mr_strobe_active", SRAM_WE_N, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mr_we_n", SRAM_WE_N, 1'b1);
        check("mr_busy", clr_busy, 1'b1);
        check("mr_wr_ready", wr_ready, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_clear("mr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
